alu_2_arbiter: RTL

Round-robin arbiter and issue sequencer that shares one `alu_2` instance among NUM_REQ requesters inside an RMT action stage. It accepts action/operand bundles over valid/ready handshakes and issues at most one per cycle to the ALU. It tracks in-flight operations by requester tag and routes each ALU result back to its originator. It also blocks load/store hazards on the ALU's stateful memory and provides a drain/halt mode for safe reconfiguration.

---
 rtl/alu_2_pkg.sv | 26 ++
 rtl/alu_2_arbiter_rr.sv | 20 ++
 rtl/alu_2_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_2_pkg.sv
// alu_2_pkg: opcodes, action field positions, FSM encoding and tag type shared by the alu_2 arbiter
package alu_2_pkg;
    localparam int OP_MSB   = 24;
    localparam int OP_LSB   = 21;
    localparam int ADDR_MSB = 20;
    localparam int ADDR_LSB = 16;
    localparam int ID_W     = 3;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;
    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
        logic            st;
        logic [4:0]      addr;
    } tag_t;
    function automatic logic is_stateful(input logic [3:0] op);
        return (op == OP_STORE) || (op == OP_LOAD);
    endfunction
endpackage

// File: rtl/alu_2_arbiter_rr.sv
// rr_arbiter: one-hot grant to the first eligible requester at or after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [2*N-1:0] rot_dbl, back_dbl;
    logic [N-1:0]   rot, pick;
    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_dbl  = {elig, elig} >> ptr;
        rot      = rot_dbl[N-1:0];
        pick     = rot & (~rot + N'(1));
        back_dbl = {pick, pick} << ptr;
        gnt      = back_dbl[2*N-1:N];
    end
endmodule

// File: rtl/alu_2_arbiter.sv
// alu_2_arbiter: round-robin issue of requester bundles onto one shared alu_2 with hazard, drain and response routing
module alu_2_arbiter
    import alu_2_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int ALU_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ACTION_LEN-1:0] req_action,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op3,
    output logic [ACTION_LEN-1:0]         action_out,
    output logic                          action_valid_out,
    output logic [DATA_WIDTH-1:0]         operand_1_out,
    output logic [DATA_WIDTH-1:0]         operand_2_out,
    output logic [DATA_WIDTH-1:0]         operand_3_out,
    input  logic [DATA_WIDTH-1:0]         container_in,
    input  logic                          container_in_valid,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    input  logic                          drain_req,
    output logic                          drained,
    output logic                          proto_err
);
    localparam int PW = $clog2(NUM_REQ);

    state_t                 state_q, state_d;
    logic                   drained_q;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d, g;
    logic [NUM_REQ-1:0]     elig, gnt;
    logic                   hs, pend;
    logic [31:0]            busy;
    logic [ACTION_LEN-1:0]  action_q, action_d;
    logic [DATA_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    tag_t                   issue_q, issue_d;
    tag_t [ALU_LAT-1:0]     tag_q, tag_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d, proto_err_q, proto_err_d;

    // Addresses held by stateful ops anywhere between issue and retire.
    always_comb begin
        busy = '0;
        if (issue_q.v && issue_q.st) busy[issue_q.addr] = 1'b1;
        for (int s = 0; s < ALU_LAT; s++)
            if (tag_q[s].v && tag_q[s].st) busy[tag_q[s].addr] = 1'b1;
    end

    // A requester competes only in RUN, without a same-cycle drain, and when its stateful address is free.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && state_q == ST_RUN && !drain_req
                   && !(is_stateful(req_action[i*ACTION_LEN+OP_LSB +: 4])
                        && busy[req_action[i*ACTION_LEN+ADDR_LSB +: 5]]);
    end

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .elig (elig),
        .ptr  (rr_ptr_q),
        .gnt  (gnt)
    );

    // Select the granted bundle for the issue register and advance the pointer past the winner.
    always_comb begin
        g        = '0;
        action_d = '0;
        op1_d    = '0;
        op2_d    = '0;
        op3_d    = '0;
        issue_d  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) begin
                g        = PW'(i);
                action_d = req_action[i*ACTION_LEN +: ACTION_LEN];
                op1_d    = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
                op2_d    = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
                op3_d    = req_op3[i*DATA_WIDTH +: DATA_WIDTH];
            end
        hs           = |gnt;
        issue_d.v    = hs;
        issue_d.id   = ID_W'(g);
        issue_d.st   = hs && is_stateful(action_d[OP_MSB:OP_LSB]);
        issue_d.addr = action_d[ADDR_MSB:ADDR_LSB];
        rr_ptr_d     = !hs ? rr_ptr_q : (g == PW'(NUM_REQ-1)) ? '0 : g + 1'b1;
    end

    // Shift tags toward retire, route the retiring result and work out the next FSM state.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = issue_q;
        for (int s = 1; s < ALU_LAT; s++) tag_d[s] = tag_q[s-1];
        pend = issue_d.v;
        for (int s = 0; s < ALU_LAT; s++) pend = pend | tag_d[s].v;
        resp_valid_d = tag_q[ALU_LAT-1].v ? NUM_REQ'(1) << tag_q[ALU_LAT-1].id : '0;
        resp_data_d  = tag_q[ALU_LAT-1].v ? container_in : '0;
        resp_err_d   = tag_q[ALU_LAT-1].v && !container_in_valid;
        proto_err_d  = proto_err_q || (container_in_valid && !tag_q[ALU_LAT-1].v);
        state_d = (state_q == ST_RUN)   ? (drain_req ? ST_DRAIN : ST_RUN)
                : (state_q == ST_DRAIN) ? (pend ? ST_DRAIN : ST_HALT)
                :                         (drain_req ? ST_HALT : ST_RUN);
    end

    // Datapath registers: issue stage, tag pipeline, pointer and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            action_q     <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            op3_q        <= '0;
            issue_q      <= '0;
            tag_q        <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            action_q     <= action_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            op3_q        <= op3_d;
            issue_q      <= issue_d;
            tag_q        <= tag_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Run/drain/halt state with a registered drained flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drained_q <= (state_d == ST_HALT);
        end
    end

    assign req_ready        = gnt;
    assign action_out       = action_q;
    assign action_valid_out = issue_q.v;
    assign operand_1_out    = op1_q;
    assign operand_2_out    = op2_q;
    assign operand_3_out    = op3_q;
    assign resp_valid       = resp_valid_q;
    assign resp_data        = resp_data_q;
    assign resp_err         = resp_err_q;
    assign drained          = drained_q;
    assign proto_err        = proto_err_q;
endmodule
